if_hazard_ctrl: RTL and testbench
=================================

Name: if_hazard_ctrl

Overview:
Sequencing controller for the fetch stage. It drives the IF enable input and the IF/ID and ID/EX pipeline-register controls. It decides, every cycle, whether the PC advances, holds or is redirected, and whether bubbles are inserted. It arbitrates among the following stall and flush sources:
- taken branch resolved in EX
- jump decoded in ID (J/Jal/Jr)
- load-use hazard
- instruction-memory wait
- external halt

Parameters:
FLUSH_DEPTH, 2, cycles ifid_flush stays high after a taken branch (1..7)
LU_STALL, 1, stall cycles inserted on a load-use hazard (1..3)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  clock, all state on rising edge
init  input  1  synchronous active-low reset
halt_req  input  1  request to freeze fetch
resume  input  1  leave HALTED (pulse)
branch_taken  input  1  EX-stage branch condition true (BEQ/BNE/BGTZ/BGEZ/BLEZ resolved)
jump_id  input  1  J, Jal or Jr decoded in ID
ex_mem_read  input  1  instruction in EX is a load
ex_rt  input  5  load destination register in EX
id_rs  input  5  rs of instruction in ID
id_rt  input  5  rt of instruction in ID
id_uses_rt  input  1  ID instruction reads rt
imem_ready  input  1  instruction memory returns valid word this cycle
pc_enable  output  1  to IF enable; 1 = PC updates
ifid_enable  output  1  IF/ID register load
ifid_flush  output  1  IF/ID register cleared to NOP
idex_flush  output  1  ID/EX register cleared to NOP
state  output  3  current state code (debug)

Behaviour:
- Reset (init=0 at a clk edge):
  - state=RUN, counters=0
  - outputs pc_enable=1, ifid_enable=1, ifid_flush=0, idex_flush=0
  - Reset mid-operation aborts any stall or flush immediately.
- Outputs are registered from state plus a Moore decode, except that redirect and hazard detection act combinationally in the same cycle (Mealy) as listed.
- Load-use hazard (lu): ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Priority, highest first: halt_req > branch_taken > jump_id > lu > !imem_ready.
- States: RUN=0, FLUSH=1, LU_WAIT=2, MEM_WAIT=3, HALTED=4.
- RUN:
  - halt_req: all enables 0, next HALTED.
  - branch_taken: pc_enable=1, ifid_flush=1, idex_flush=1. If FLUSH_DEPTH>1, load flush counter with FLUSH_DEPTH-1 and go to FLUSH; else stay in RUN.
  - jump_id: pc_enable=1, ifid_flush=1 for exactly this cycle; stay in RUN.
  - lu: pc_enable=0, ifid_enable=0, idex_flush=1. If LU_STALL>1, load counter with LU_STALL-1 and go to LU_WAIT.
  - !imem_ready: pc_enable=0, ifid_enable=0, idex_flush=1, next MEM_WAIT.
- FLUSH:
  - pc_enable=1, ifid_flush=1; counter decrements each cycle, back to RUN when counter==1.
  - A new branch_taken reloads the counter with FLUSH_DEPTH-1.
  - jump_id and lu are ignored here, since the ID instruction is being flushed.
- LU_WAIT:
  - Same outputs as the lu stall; decrement the counter, return to RUN at 1.
  - branch_taken aborts the stall and takes the RUN branch_taken action.
- MEM_WAIT:
  - pc_enable=0, ifid_enable=0, idex_flush=1 until imem_ready=1; the cycle imem_ready=1 has normal RUN outputs and next RUN.
  - branch_taken: pc_enable=1 (target loaded), ifid_flush=1, go to FLUSH per the branch rule.
- HALTED:
  - All enables 0, flushes 0. Stays until resume=1 & halt_req=0, then RUN.
  - A branch_taken arriving in HALTED is not recorded.
- Simultaneous branch_taken and lu: branch wins and no stall cycle is inserted.
- Simultaneous jump_id and !imem_ready: the jump is honoured first (one cycle), then MEM_WAIT if memory is still not ready.
- The flush counter is 3 bits and must never wrap. Parameters outside their stated ranges are an elaboration error.

Optional Feature:
IF_HAZARD_PERF_EN:
- When defined, adds outputs stall_cycles[CNT_W-1:0], flush_events[CNT_W-1:0] and halt_cycles[CNT_W-1:0].
  - stall_cycles increments on every cycle with pc_enable=0 outside HALTED.
  - flush_events increments once per accepted branch_taken or jump_id.
  - halt_cycles increments each HALTED cycle.
- All counters saturate at all-ones and are cleared by init.
- When undefined, the ports and logic are absent and core behaviour is identical.

Test Plan:
- Reset then 5 idle cycles (imem_ready=1): pc_enable=1, ifid_enable=1, all flushes 0, state=0 throughout.
- ex_mem_read=1, ex_rt=5, id_rs=5, LU_STALL=1: exactly 1 cycle with pc_enable=0, idex_flush=1, then RUN. Repeat with ex_rt=0: no stall.
- branch_taken pulse, FLUSH_DEPTH=2: ifid_flush=1 for 2 cycles, idex_flush=1 first cycle only, pc_enable=1 both. Same cycle lu=1: no stall inserted.
- imem_ready low for 3 cycles: pc_enable=0 and idex_flush=1 for 3 cycles, resume on the 4th. Branch_taken on wait cycle 2 → pc_enable=1, state=FLUSH.
- halt_req during FLUSH: next state HALTED, all enables 0. resume with halt_req=1 stays HALTED; resume with halt_req=0 → RUN. init=0 mid-LU_WAIT → RUN next cycle.
- With IF_HAZARD_PERF_EN, CNT_W=4: 20 stall cycles → stall_cycles=15 (saturated); 2 branches plus 1 jump → flush_events=3.

Source files
------------

// File: rtl/if_hazard_ctrl.sv
// Fetch-stage sequencing controller: arbitrates halt, taken branch, ID jump, load-use and imem wait.
// Define IF_HAZARD_PERF_EN to add saturating stall/flush/halt performance counters.
module if_hazard_ctrl #(
  parameter int FLUSH_DEPTH = 2,
  parameter int LU_STALL    = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             init,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             imem_ready,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [2:0]       state
`ifdef IF_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] halt_cycles
`endif
);

  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 7) begin : g_bad_flush_depth
    $error("if_hazard_ctrl: FLUSH_DEPTH must be in 1..7");
  end
  if (LU_STALL < 1 || LU_STALL > 3) begin : g_bad_lu_stall
    $error("if_hazard_ctrl: LU_STALL must be in 1..3");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("if_hazard_ctrl: CNT_W must be at least 1");
  end

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    FLUSH    = 3'd1,
    LU_WAIT  = 3'd2,
    MEM_WAIT = 3'd3,
    HALTED   = 3'd4
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [2:0] LU_LOAD    = 3'(LU_STALL - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lu;
  logic       run_mode;

  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // The cycle memory comes back inside MEM_WAIT is arbitrated exactly like RUN.
  assign run_mode = (state_q == RUN) || ((state_q == MEM_WAIT) && imem_ready);

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (!init) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_enable   = 1'b1;
    ifid_enable = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (init) begin
      if (state_q == HALTED) begin
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        if (resume && !halt_req) begin
          state_d = RUN;
        end
      end else if (halt_req) begin
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        state_d     = HALTED;
      end else if (branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (FLUSH_DEPTH > 1) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else begin
          state_d = RUN;
        end
      end else begin
        case (state_q)
          FLUSH: begin
            ifid_flush = 1'b1;
            if (cnt_q > 3'd1) begin
              cnt_d = cnt_q - 3'd1;
            end else begin
              state_d = RUN;
            end
          end
          LU_WAIT: begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_flush  = 1'b1;
            if (cnt_q > 3'd1) begin
              cnt_d = cnt_q - 3'd1;
            end else begin
              state_d = RUN;
            end
          end
          default: begin
            if (!run_mode) begin
              pc_enable   = 1'b0;
              ifid_enable = 1'b0;
              idex_flush  = 1'b1;
              state_d     = MEM_WAIT;
            end else if (jump_id) begin
              ifid_flush = 1'b1;
              state_d    = RUN;
            end else if (lu) begin
              pc_enable   = 1'b0;
              ifid_enable = 1'b0;
              idex_flush  = 1'b1;
              if (LU_STALL > 1) begin
                state_d = LU_WAIT;
                cnt_d   = LU_LOAD;
              end else begin
                state_d = RUN;
              end
            end else if (!imem_ready) begin
              pc_enable   = 1'b0;
              ifid_enable = 1'b0;
              idex_flush  = 1'b1;
              state_d     = MEM_WAIT;
            end else begin
              state_d = RUN;
            end
          end
        endcase
      end
    end
  end

`ifdef IF_HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic br_accept;
  logic jmp_accept;

  // A jump only counts when it wins arbitration, i.e. nothing above it fired.
  assign br_accept  = init && (state_q != HALTED) && !halt_req && branch_taken;
  assign jmp_accept = init && (state_q != HALTED) && !halt_req && !branch_taken &&
                      jump_id && run_mode;

  always_ff @(posedge clk) begin
    if (!init) begin
      stall_cycles <= '0;
      flush_events <= '0;
      halt_cycles  <= '0;
    end else begin
      if (!pc_enable && (state_q != HALTED) && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if ((br_accept || jmp_accept) && (flush_events != CNT_MAX)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
      if ((state_q == HALTED) && (halt_cycles != CNT_MAX)) begin
        halt_cycles <= halt_cycles + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// Directed self-checking bench for if_hazard_ctrl: a default-parameter instance plus a
// FLUSH_DEPTH=3 / LU_STALL=3 instance; perf counters are checked when IF_HAZARD_PERF_EN is set.
module tb_if_hazard_ctrl;

  logic       clk = 1'b0;
  logic       init;
  logic       halt_req;
  logic       resume;
  logic       branch_taken;
  logic       jump_id;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       imem_ready;

  logic       pc_enable, ifid_enable, ifid_flush, idex_flush;
  logic [2:0] state;
  logic       pc_enable3, ifid_enable3, ifid_flush3, idex_flush3;
  logic [2:0] state3;
`ifdef IF_HAZARD_PERF_EN
  logic [3:0]  stall_cycles, flush_events, halt_cycles;
  logic [15:0] stall_cycles3, flush_events3, halt_cycles3;
`endif

  logic [6:0] obs, obs3;
  assign obs  = {pc_enable, ifid_enable, ifid_flush, idex_flush, state};
  assign obs3 = {pc_enable3, ifid_enable3, ifid_flush3, idex_flush3, state3};

  int n_cmp = 0;
  int n_bad = 0;

  // {pc_enable, ifid_enable, ifid_flush, idex_flush, state}
  localparam logic [6:0] O_RUN       = 7'b1100_000;
  localparam logic [6:0] O_JMP       = 7'b1110_000;
  localparam logic [6:0] O_BR_RUN    = 7'b1111_000;
  localparam logic [6:0] O_BR_FLUSH  = 7'b1111_001;
  localparam logic [6:0] O_BR_LW     = 7'b1111_010;
  localparam logic [6:0] O_BR_MW     = 7'b1111_011;
  localparam logic [6:0] O_FLUSH     = 7'b1110_001;
  localparam logic [6:0] O_STALL_RUN = 7'b0001_000;
  localparam logic [6:0] O_STALL_LW  = 7'b0001_010;
  localparam logic [6:0] O_STALL_MW  = 7'b0001_011;
  localparam logic [6:0] O_MW_READY  = 7'b1100_011;
  localparam logic [6:0] O_HALT_RUN  = 7'b0000_000;
  localparam logic [6:0] O_HALT_FL   = 7'b0000_001;
  localparam logic [6:0] O_HALTED    = 7'b0000_100;

  // stimulus step code: {halt_req, resume, branch_taken, jump_id, load_use, imem_ready}
  localparam logic [5:0] S_IDLE = 6'b000001;
  localparam logic [5:0] S_BR   = 6'b001001;
  localparam logic [5:0] S_JMP  = 6'b000101;
  localparam logic [5:0] S_LU   = 6'b000011;
  localparam logic [5:0] S_NRDY = 6'b000000;

  if_hazard_ctrl u_dut (
    .clk          (clk),
    .init         (init),
    .halt_req     (halt_req),
    .resume       (resume),
    .branch_taken (branch_taken),
    .jump_id      (jump_id),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .imem_ready   (imem_ready),
    .pc_enable    (pc_enable),
    .ifid_enable  (ifid_enable),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .state        (state)
`ifdef IF_HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .halt_cycles  (halt_cycles)
`endif
  );
`ifdef IF_HAZARD_PERF_EN
  defparam u_dut.CNT_W = 4;
`endif

  if_hazard_ctrl #(.FLUSH_DEPTH(3), .LU_STALL(3)) u_dut3 (
    .clk          (clk),
    .init         (init),
    .halt_req     (halt_req),
    .resume       (resume),
    .branch_taken (branch_taken),
    .jump_id      (jump_id),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .imem_ready   (imem_ready),
    .pc_enable    (pc_enable3),
    .ifid_enable  (ifid_enable3),
    .ifid_flush   (ifid_flush3),
    .idex_flush   (idex_flush3),
    .state        (state3)
`ifdef IF_HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles3),
    .flush_events (flush_events3),
    .halt_cycles  (halt_cycles3)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] s);
    halt_req     = s[5];
    resume       = s[4];
    branch_taken = s[3];
    jump_id      = s[2];
    ex_mem_read  = s[1];
    ex_rt        = s[1] ? 5'd5 : 5'd0;
    id_rs        = 5'd5;
    id_rt        = 5'd0;
    id_uses_rt   = 1'b0;
    imem_ready   = s[0];
  endtask

  task automatic test_reset();
    drive(S_IDLE);
    init = 1'b0;
    tick();
    init = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN) begin
        n_bad++;
        $display("[TB] FAIL reset_idle[%0d]: got %b want %b", i, obs, O_RUN);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    // {ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt}
    logic [16:0] v   [0:5];
    logic [6:0]  exp [0:5];
    v   = '{{1'b1, 5'd5, 5'd5, 5'd0, 1'b0}, {1'b0, 5'd0, 5'd5, 5'd0, 1'b0},
            {1'b1, 5'd0, 5'd0, 5'd0, 1'b0}, {1'b1, 5'd7, 5'd1, 5'd7, 1'b1},
            {1'b1, 5'd7, 5'd1, 5'd7, 1'b0}, {1'b0, 5'd5, 5'd5, 5'd5, 1'b1}};
    exp = '{O_STALL_RUN, O_RUN, O_RUN, O_STALL_RUN, O_RUN, O_RUN};
    drive(S_IDLE);
    for (int i = 0; i < 6; i++) begin
      {ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt} = v[i];
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("[TB] FAIL load_use[%0d]: got %b want %b", i, obs, exp[i]);
      end
      tick();
    end
    drive(S_IDLE);
  endtask

  task automatic test_branch();
    logic [5:0] stim [0:9];
    logic [6:0] exp  [0:9];
    stim = '{6'b001011, S_IDLE, S_IDLE, S_BR, S_BR, S_IDLE, S_IDLE, S_BR, 6'b000111, S_IDLE};
    exp  = '{O_BR_RUN, O_FLUSH, O_RUN, O_BR_RUN, O_BR_FLUSH, O_FLUSH, O_RUN,
             O_BR_RUN, O_FLUSH, O_RUN};
    for (int i = 0; i < 10; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("[TB] FAIL branch[%0d]: got %b want %b", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_jump();
    logic [5:0] stim [0:7];
    logic [6:0] exp  [0:7];
    stim = '{S_JMP, S_IDLE, 6'b000100, S_NRDY, S_IDLE, S_IDLE, 6'b000111, S_IDLE};
    exp  = '{O_JMP, O_RUN, O_JMP, O_STALL_RUN, O_MW_READY, O_RUN, O_JMP, O_RUN};
    for (int i = 0; i < 8; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("[TB] FAIL jump[%0d]: got %b want %b", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] stim [0:8];
    logic [6:0] exp  [0:8];
    stim = '{S_NRDY, S_NRDY, S_NRDY, S_IDLE, S_IDLE, S_NRDY, 6'b001000, S_IDLE, S_IDLE};
    exp  = '{O_STALL_RUN, O_STALL_MW, O_STALL_MW, O_MW_READY, O_RUN,
             O_STALL_RUN, O_BR_MW, O_FLUSH, O_RUN};
    for (int i = 0; i < 9; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("[TB] FAIL mem_wait[%0d]: got %b want %b", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [5:0] stim [0:9];
    logic [6:0] exp  [0:9];
    stim = '{S_BR, 6'b100001, 6'b111001, S_IDLE, 6'b010001, S_IDLE,
             6'b101001, S_IDLE, 6'b010001, S_IDLE};
    exp  = '{O_BR_RUN, O_HALT_FL, O_HALTED, O_HALTED, O_HALTED, O_RUN,
             O_HALT_RUN, O_HALTED, O_HALTED, O_RUN};
    for (int i = 0; i < 10; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("[TB] FAIL halt[%0d]: got %b want %b", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_deep_params();
    logic [5:0] stim [0:13];
    logic [6:0] exp  [0:13];
    stim = '{S_LU, S_IDLE, S_IDLE, S_IDLE, S_BR, S_IDLE, S_IDLE, S_IDLE,
             S_LU, S_BR, S_IDLE, S_IDLE, S_IDLE, S_LU};
    exp  = '{O_STALL_RUN, O_STALL_LW, O_STALL_LW, O_RUN, O_BR_RUN, O_FLUSH, O_FLUSH, O_RUN,
             O_STALL_RUN, O_BR_LW, O_FLUSH, O_FLUSH, O_RUN, O_STALL_RUN};
    drive(S_IDLE);
    init = 1'b0;
    tick();
    init = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_cmp++;
      if (obs3 !== exp[i]) begin
        n_bad++;
        $display("[TB] FAIL deep[%0d]: got %b want %b", i, obs3, exp[i]);
      end
      tick();
    end
    // u_dut3 now sits in LU_WAIT with two stall cycles left; reset must cut it short.
    drive(S_IDLE);
    init = 1'b0;
    tick();
    init = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs3 !== O_RUN) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_lu: got %b want %b", obs3, O_RUN);
    end
    tick();
  endtask

`ifdef IF_HAZARD_PERF_EN
  task automatic test_perf();
    logic [5:0] stim [0:11];
    stim = '{S_BR, S_IDLE, S_IDLE, S_BR, S_IDLE, S_IDLE, S_JMP, S_IDLE,
             6'b100001, S_IDLE, S_IDLE, 6'b010001};
    drive(S_IDLE);
    init = 1'b0;
    tick();
    init = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(S_NRDY);
      tick();
    end
    drive(S_IDLE);
    @(negedge clk);
    n_cmp++;
    if (stall_cycles !== 4'd15) begin
      n_bad++;
      $display("[TB] FAIL perf_stall_sat: got %0d want 15", stall_cycles);
    end
    n_cmp++;
    if (flush_events !== 4'd0) begin
      n_bad++;
      $display("[TB] FAIL perf_flush_zero: got %0d want 0", flush_events);
    end
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(stim[i]);
      tick();
    end
    drive(S_IDLE);
    @(negedge clk);
    n_cmp++;
    if (flush_events !== 4'd3) begin
      n_bad++;
      $display("[TB] FAIL perf_flush_events: got %0d want 3", flush_events);
    end
    n_cmp++;
    if (halt_cycles !== 4'd3) begin
      n_bad++;
      $display("[TB] FAIL perf_halt_cycles: got %0d want 3", halt_cycles);
    end
    n_cmp++;
    if (stall_cycles !== 4'd15) begin
      n_bad++;
      $display("[TB] FAIL perf_stall_hold: got %0d want 15", stall_cycles);
    end
    tick();
  endtask
`endif

  initial begin
    init = 1'b0;
    drive(S_IDLE);
    test_reset();
    test_load_use();
    test_branch();
    test_jump();
    test_mem_wait();
    test_halt();
    test_deep_params();
`ifdef IF_HAZARD_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
